// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start is accepted in IDLE; done pulses W edges later with all four digits registered on that edge.
module bin_to_bcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [3:0]   dig_thou,
  output logic [3:0]   dig_hund,
  output logic [3:0]   dig_tens,
  output logic [3:0]   dig_ones
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [W-1:0]  sh;
  logic [15:0]   scr;
  logic [CW-1:0] cnt;
  logic          ovf_pending;

  logic [15:0]   scr_adj;
  logic [W+15:0] cat_next;
  logic [15:0]   scr_next;
  logic [W-1:0]  sh_next;
  logic          too_big;

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    scr_adj = scr;
    for (int i = 0; i < 4; i++) begin
      if (scr[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end
    end
  end

  assign cat_next = {scr_adj, sh} << 1;
  assign scr_next = cat_next[W+15:W];
  assign sh_next  = cat_next[W-1:0];

  // Only widths of 14 bits or more can exceed four decimal digits.
  assign too_big  = 32'(bin) > 32'd9999;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      sh          <= '0;
      scr         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      dig_thou    <= 4'h0;
      dig_hund    <= 4'h0;
      dig_tens    <= 4'h0;
      dig_ones    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh          <= bin;
            scr         <= '0;
            cnt         <= CW'(W);
            ovf_pending <= too_big;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= scr_next;
          sh  <= sh_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= ovf_pending;
            if (ovf_pending) begin
              dig_thou <= 4'hE;
              dig_hund <= 4'hE;
              dig_tens <= 4'hE;
              dig_ones <= 4'hE;
            end else begin
              dig_thou <= scr_next[15:12];
              dig_hund <= scr_next[11:8];
              dig_tens <= scr_next[7:4];
              dig_ones <= scr_next[3:0];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq at W = 8, 5, 14 and 1 sharing one clock and reset.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic [3:0]        start_v;
  logic [3:0][13:0]  bin_v;
  logic [3:0]        busy_v, done_v, ovf_v;
  logic [3:0][15:0]  dig_v;

  int vectors = 0;
  int miscompares = 0;

  bin_to_bcd_seq #(.W(8)) u8 (
    .clk(clk), .clr(clr), .start(start_v[0]), .bin(bin_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .ovf(ovf_v[0]),
    .dig_thou(dig_v[0][15:12]), .dig_hund(dig_v[0][11:8]),
    .dig_tens(dig_v[0][7:4]), .dig_ones(dig_v[0][3:0]));

  bin_to_bcd_seq #(.W(5)) u5 (
    .clk(clk), .clr(clr), .start(start_v[1]), .bin(bin_v[1][4:0]),
    .busy(busy_v[1]), .done(done_v[1]), .ovf(ovf_v[1]),
    .dig_thou(dig_v[1][15:12]), .dig_hund(dig_v[1][11:8]),
    .dig_tens(dig_v[1][7:4]), .dig_ones(dig_v[1][3:0]));

  bin_to_bcd_seq #(.W(14)) u14 (
    .clk(clk), .clr(clr), .start(start_v[2]), .bin(bin_v[2][13:0]),
    .busy(busy_v[2]), .done(done_v[2]), .ovf(ovf_v[2]),
    .dig_thou(dig_v[2][15:12]), .dig_hund(dig_v[2][11:8]),
    .dig_tens(dig_v[2][7:4]), .dig_ones(dig_v[2][3:0]));

  bin_to_bcd_seq #(.W(1)) u1 (
    .clk(clk), .clr(clr), .start(start_v[3]), .bin(bin_v[3][0:0]),
    .busy(busy_v[3]), .done(done_v[3]), .ovf(ovf_v[3]),
    .dig_thou(dig_v[3][15:12]), .dig_hund(dig_v[3][11:8]),
    .dig_tens(dig_v[3][7:4]), .dig_ones(dig_v[3][3:0]));

  function automatic logic [15:0] bcd16(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One-cycle start on instance k, then the input is scrambled to prove it was latched.
  // lat = edges from the start edge to the done edge; bcnt = sampled cycles with busy high.
  task automatic convert(input int k, input logic [13:0] b, output int lat, output int bcnt);
    @(negedge clk);
    start_v[k] = 1'b1;
    bin_v[k]   = b;
    @(negedge clk);
    start_v[k] = 1'b0;
    bin_v[k]   = ~b;
    lat  = 0;
    bcnt = 0;
    while (lat < 40 && done_v[k] !== 1'b1) begin
      if (busy_v[k] === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy_v, done_v, ovf_v} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_flags: got %h want 000", {busy_v, done_v, ovf_v});
    end
    vectors++;
    if (dig_v !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_digits: got %h want 0", dig_v);
    end
    clr = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    convert(0, 14'd255, lat, bc);
    vectors++;
    if (lat !== 8) begin miscompares++; $display("FAIL basic_latency: got %0d want 8", lat); end
    vectors++;
    if (bc !== 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    vectors++;
    if (dig_v[0] !== 16'h0255 || ovf_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got dig %h ovf %b busy %b want 0255 0 0", dig_v[0], ovf_v[0], busy_v[0]);
    end
    @(negedge clk);
    vectors++;
    if (done_v[0] !== 1'b0 || dig_v[0] !== 16'h0255) begin
      miscompares++;
      $display("FAIL basic_done_pulse: got done %b dig %h want 0 0255", done_v[0], dig_v[0]);
    end
  endtask

  task automatic test_clr_abort();
    int dones;
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 14'd200;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 clr = 1'b1;
    #1;
    vectors++;
    if ({busy_v[0], done_v[0], ovf_v[0]} !== 3'b000 || dig_v[0] !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_abort_immediate: got flags %b%b%b dig %h want 000 0000",
               busy_v[0], done_v[0], ovf_v[0], dig_v[0]);
    end
    @(negedge clk);
    clr   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0 || dig_v[0] !== 16'h0000 || busy_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_abort_after: got dones %0d dig %h busy %b want 0 0000 0", dones, dig_v[0], busy_v[0]);
    end
  endtask

  task automatic test_zero_nibble();
    int lat, bc;
    convert(1, 14'd0, lat, bc);
    vectors++;
    if (lat !== 5 || dig_v[1] !== 16'h0000) begin
      miscompares++;
      $display("FAIL w5_zero: got lat %0d dig %h want 5 0000", lat, dig_v[1]);
    end
    convert(1, 14'd19, lat, bc);
    vectors++;
    if (lat !== 5 || bc !== 5 || dig_v[1] !== 16'h0019) begin
      miscompares++;
      $display("FAIL w5_19: got lat %0d busy %0d dig %h want 5 5 0019", lat, bc, dig_v[1]);
    end
    convert(1, 14'd31, lat, bc);
    vectors++;
    if (dig_v[1] !== 16'h0031) begin
      miscompares++;
      $display("FAIL w5_31: got %h want 0031", dig_v[1]);
    end
  endtask

  task automatic test_ignored_start();
    int dones, t, nd;
    int td[3];
    logic [15:0] dd;
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 14'd123;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 14'd77;
    @(negedge clk);
    start_v[0] = 1'b0;
    dones = 0;
    dd    = 16'hFFFF;
    repeat (22) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        dones++;
        dd = dig_v[0];
      end
    end
    vectors++;
    if (dones !== 1 || dd !== 16'h0123) begin
      miscompares++;
      $display("FAIL ignored_start: got dones %0d dig %h want 1 0123", dones, dd);
    end
    // Held start: back-to-back conversions every W+1 cycles.
    @(negedge clk);
    start_v[0] = 1'b1;
    bin_v[0]   = 14'd77;
    nd = 0;
    t  = 0;
    while (nd < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (done_v[0] === 1'b1) begin
        td[nd] = t;
        nd++;
        vectors++;
        if (dig_v[0] !== 16'h0077) begin
          miscompares++;
          $display("FAIL held_digits: got %h want 0077", dig_v[0]);
        end
      end
    end
    start_v[0] = 1'b0;
    vectors++;
    if (nd !== 3) begin
      miscompares++;
      $display("FAIL held_count: got %0d dones want 3", nd);
    end else begin
      vectors++;
      if (td[1] - td[0] !== 9 || td[2] - td[1] !== 9) begin
        miscompares++;
        $display("FAIL held_period: got %0d %0d want 9 9", td[1] - td[0], td[2] - td[1]);
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat, bc;
    convert(2, 14'd9999, lat, bc);
    vectors++;
    if (lat !== 14 || dig_v[2] !== 16'h9999 || ovf_v[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL w14_9999: got lat %0d dig %h ovf %b want 14 9999 0", lat, dig_v[2], ovf_v[2]);
    end
    convert(2, 14'd10000, lat, bc);
    vectors++;
    if (dig_v[2] !== 16'hEEEE || ovf_v[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL w14_10000: got dig %h ovf %b want EEEE 1", dig_v[2], ovf_v[2]);
    end
    convert(2, 14'd16383, lat, bc);
    vectors++;
    if (dig_v[2] !== 16'hEEEE || ovf_v[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL w14_16383: got dig %h ovf %b want EEEE 1", dig_v[2], ovf_v[2]);
    end
    convert(2, 14'd42, lat, bc);
    vectors++;
    if (dig_v[2] !== 16'h0042 || ovf_v[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL w14_42: got dig %h ovf %b want 0042 0", dig_v[2], ovf_v[2]);
    end
  endtask

  task automatic test_w1();
    int lat, bc;
    convert(3, 14'd1, lat, bc);
    vectors++;
    if (lat !== 1 || bc !== 1 || dig_v[3] !== 16'h0001) begin
      miscompares++;
      $display("FAIL w1_one: got lat %0d busy %0d dig %h want 1 1 0001", lat, bc, dig_v[3]);
    end
    convert(3, 14'd0, lat, bc);
    vectors++;
    if (dig_v[3] !== 16'h0000) begin
      miscompares++;
      $display("FAIL w1_zero: got %h want 0000", dig_v[3]);
    end
  endtask

  task automatic test_stability();
    int pend;
    logic [15:0] held;
    pend = 77;
    held = 16'h0077;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) held = bcd16(pend);
      vectors++;
      if (dig_v[0] !== held) begin
        miscompares++;
        $display("FAIL stability_c%0d: got %h want %h", c, dig_v[0], held);
      end
      start_v[0] = 1'b0;
      if (busy_v[0] === 1'b0 && $urandom_range(0, 2) == 0) begin
        pend       = int'($urandom_range(0, 255));
        start_v[0] = 1'b1;
        bin_v[0]   = 14'(pend);
      end else begin
        bin_v[0] = 14'($urandom_range(0, 255));
      end
    end
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    clr     = 1'b1;
    start_v = '0;
    bin_v   = '0;
    test_reset();
    test_basic();
    test_clr_abort();
    test_zero_nibble();
    test_ignored_start();
    test_overflow();
    test_w1();
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
